// File: rtl/softcore_pkg.sv
// Shared softcore definitions: fetch FSM state encoding and datapath defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: SOFTCORE_DATA_WIDTH, SOFTCORE_RESET_VECTOR, fetch_state_t,
//           timeout_cnt_width() helper for the optional fetch watchdog.
package softcore_pkg;

  localparam int unsigned SOFTCORE_DATA_WIDTH   = 16;
  localparam logic [15:0] SOFTCORE_RESET_VECTOR = 16'h0000;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

  // Counter width able to hold the value TimeoutCycles itself.
  function automatic int unsigned timeout_cnt_width(input int unsigned cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/Register.sv
// Generic loadable register, used by the fetch stage as the program counter.
// Latency: DIn appears on DOut one cycle after a load strobe.
// Backpressure: none; loads whenever LD is low.
// Ports: Clk; Reset (sync, active-low, clears to 0); LD (active-low load);
//        DIn (next value); DOut (stored value).
module Register #(
  parameter int unsigned DataWidth = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 LD,
  input  logic [DataWidth-1:0] DIn,
  output logic [DataWidth-1:0] DOut
);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      DOut <= '0;
    end else if (!LD) begin
      DOut <= DIn;
    end
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch-stage controller: owns the PC register, runs the IReq/IAck memory
// handshake and hands fetched words to decode over InstrValid/DecReady.
// Latency: IReq 1 cycle after reset release, InstrValid 1 cycle after IAck;
//          peak rate 1 instruction per 2 cycles.
// Backpressure: Instr held in HOLD until DecReady & ~Stall (or a branch drops
//               it); a FETCH request is never aborted, only redirected after ack.
// Ports: Clk, Reset (sync active-high); IReq/IAddr/IAck/IData memory side;
//        InstrValid/Instr/DecReady/Stall decode side; BrTaken/BrTarget
//        redirect; FetchErr sticky watchdog flag.
// Macro: PC_FETCH_TIMEOUT_EN enables the FETCH watchdog (TimeoutCycles) and
//        the HALT state; without it FETCH waits forever and FetchErr is 0.
module pc_fetch_sequencer
  import softcore_pkg::*;
#(
  parameter int unsigned          DataWidth     = SOFTCORE_DATA_WIDTH,
  parameter logic [DataWidth-1:0] ResetVector   = DataWidth'(SOFTCORE_RESET_VECTOR),
  parameter int unsigned          StepSize      = 1,
  parameter int unsigned          TimeoutCycles = 255
) (
  input  logic                 Clk,
  input  logic                 Reset,
  output logic                 IReq,
  output logic [DataWidth-1:0] IAddr,
  input  logic                 IAck,
  input  logic [DataWidth-1:0] IData,
  output logic                 InstrValid,
  output logic [DataWidth-1:0] Instr,
  input  logic                 DecReady,
  input  logic                 Stall,
  input  logic                 BrTaken,
  input  logic [DataWidth-1:0] BrTarget,
  output logic                 FetchErr
);

  fetch_state_t         state;
  logic                 redir_pend;
  logic [DataWidth-1:0] redir_target;

  logic                 pc_rst_n;
  logic                 pc_ld_n;
  logic [DataWidth-1:0] pc_din;
  logic [DataWidth-1:0] pc_inc;
  logic                 accept;
  logic                 timeout_hit;

  // IAddr is the PC itself, so a PC load is visible on the bus next cycle.
  Register #(
    .DataWidth (DataWidth)
  ) pc_reg (
    .Clk   (Clk),
    .Reset (pc_rst_n),
    .LD    (pc_ld_n),
    .DIn   (pc_din),
    .DOut  (IAddr)
  );

  assign pc_rst_n = ~Reset;
  assign pc_inc   = IAddr + DataWidth'(StepSize);
  assign accept   = DecReady & ~Stall;

`ifdef PC_FETCH_TIMEOUT_EN
  localparam int unsigned CntWidth = timeout_cnt_width(TimeoutCycles);

  logic [CntWidth-1:0] to_cnt;
  logic [CntWidth-1:0] to_cnt_inc;

  assign to_cnt_inc = to_cnt + 1'b1;

  // Fires on the TimeoutCycles-th consecutive FETCH cycle without IAck.
  assign timeout_hit = (state == ST_FETCH) && !IAck &&
                       (to_cnt_inc == CntWidth'(TimeoutCycles));

  // Held at zero outside FETCH, so it starts from zero on every FETCH entry;
  // an ack starts a new request and so also restarts the count.
  always_ff @(posedge Clk) begin
    if (Reset || (state != ST_FETCH) || IAck) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt_inc;
    end
  end
`else
  logic timeout_cfg_unused;
  assign timeout_cfg_unused = (TimeoutCycles != 0);
  assign timeout_hit        = 1'b0;
`endif

  // PC load select. Mirrors the FSM priorities: timeout, then branch, then
  // ack/accept. A branch in FETCH without ack only loads later via
  // redir_target, since the outstanding request must keep its address.
  always_comb begin
    pc_ld_n = 1'b1;
    pc_din  = ResetVector;
    case (state)
      ST_RESET: begin
        pc_ld_n = 1'b0;
      end
      ST_FETCH: begin
        if (!timeout_hit && IAck) begin
          if (BrTaken) begin
            pc_ld_n = 1'b0;
            pc_din  = BrTarget;
          end else if (redir_pend) begin
            pc_ld_n = 1'b0;
            pc_din  = redir_target;
          end
        end
      end
      ST_HOLD: begin
        if (BrTaken) begin
          pc_ld_n = 1'b0;
          pc_din  = BrTarget;
        end else if (accept) begin
          pc_ld_n = 1'b0;
          pc_din  = pc_inc;
        end
      end
      ST_HALT: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= ST_RESET;
      IReq         <= 1'b0;
      InstrValid   <= 1'b0;
      Instr        <= '0;
      FetchErr     <= 1'b0;
      redir_pend   <= 1'b0;
      redir_target <= '0;
    end else begin
      case (state)
        ST_RESET: begin
          state <= ST_FETCH;
          IReq  <= 1'b1;
        end

        ST_FETCH: begin
          if (timeout_hit) begin
            FetchErr   <= 1'b1;
            IReq       <= 1'b0;
            redir_pend <= 1'b0;
            state      <= ST_HALT;
          end else if (BrTaken && IAck) begin
            // Returned word belongs to the old stream; refetch at the target.
            redir_pend <= 1'b0;
          end else if (BrTaken) begin
            redir_pend   <= 1'b1;
            redir_target <= BrTarget;
          end else if (IAck && redir_pend) begin
            redir_pend <= 1'b0;
          end else if (IAck) begin
            Instr      <= IData;
            InstrValid <= 1'b1;
            IReq       <= 1'b0;
            state      <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          // Branch and accept both leave HOLD; a branch simply drops Instr.
          if (BrTaken || accept) begin
            InstrValid <= 1'b0;
            IReq       <= 1'b1;
            state      <= ST_FETCH;
          end
        end

        ST_HALT: begin
          state <= ST_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Testbench for pc_fetch_sequencer: directed checks plus a randomized run
// scored against a program-order reference model (next address to deliver).
// Ports of the DUT are driven on the falling edge and sampled away from the rising edge.
module tb_pc_fetch_sequencer;

  logic        Clock_TB;
  logic        Reset;
  logic        IReq;
  logic [15:0] IAddr;
  logic        IAck;
  logic [15:0] IData;
  logic        InstrValid;
  logic [15:0] Instr;
  logic        DecReady;
  logic        Stall;
  logic        BrTaken;
  logic [15:0] BrTarget;
  logic        FetchErr;

  int          checks      = 0;
  int          fails       = 0;
  int          deliveries  = 0;
  int          noack       = 0;
  bit          mon_en      = 1'b0;
  logic [15:0] exp_q[$];
  logic [15:0] held_addr   = 16'h0000;
  logic        prev_valid  = 1'b0;
  logic        prev_ireq   = 1'b0;
  logic [15:0] prev_addr   = 16'h0000;

  localparam logic [15:0] RV = 16'h00A0;

  pc_fetch_sequencer #(
    .DataWidth     (16),
    .ResetVector   (RV),
    .StepSize      (1),
    .TimeoutCycles (4)
  ) dut (
    .Clk        (Clock_TB),
    .Reset      (Reset),
    .IReq       (IReq),
    .IAddr      (IAddr),
    .IAck       (IAck),
    .IData      (IData),
    .InstrValid (InstrValid),
    .Instr      (Instr),
    .DecReady   (DecReady),
    .Stall      (Stall),
    .BrTaken    (BrTaken),
    .BrTarget   (BrTarget),
    .FetchErr   (FetchErr)
  );

  initial Clock_TB = 1'b0;
  always #5 Clock_TB = ~Clock_TB;

  // Instruction memory contents: a bijection, so every address has a unique word.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  // Memory model: data for the current address, valid whenever IAck is driven.
  always @(negedge Clock_TB) IData = mem_word(IAddr);

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    Reset    = 1'b1;
    BrTaken  = 1'b0;
    BrTarget = 16'h0000;
    DecReady = 1'b0;
    Stall    = 1'b0;
    IAck     = 1'b1;
    @(negedge Clock_TB);
    check("rst_ireq",  {15'b0, IReq},       16'h0);
    check("rst_valid", {15'b0, InstrValid}, 16'h0);
    check("rst_err",   {15'b0, FetchErr},   16'h0);
    check("rst_instr", Instr,               16'h0000);
    check("rst_pc",    IAddr,               16'h0000);
    @(negedge Clock_TB);
    Reset = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!InstrValid && n < 64) begin
      @(negedge Clock_TB);
      n++;
    end
    if (!InstrValid) begin
      checks++;
      fails++;
      $display("FAIL %s: InstrValid not seen within 64 cycles", name);
    end
  endtask

  // Scoreboard monitor: every new presentation of an instruction must match
  // the next address predicted by the reference model.
  always @(posedge Clock_TB) begin
    #1;
    if (mon_en) begin
      if (InstrValid && !prev_valid) begin
        deliveries++;
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL sb_unexpected: got delivery at %h expected none", IAddr);
        end else begin
          held_addr = exp_q.pop_front();
          check("sb_addr",  IAddr, held_addr);
          check("sb_instr", Instr, mem_word(held_addr));
        end
      end
      // IAck seen here is the one sampled at this edge.
      if (prev_ireq && !IAck) check("sb_addr_stable", IAddr, prev_addr);
    end
    prev_valid = InstrValid;
    prev_ireq  = IReq;
    prev_addr  = IAddr;
  end

  initial begin
    Reset = 1'b1; IAck = 1'b0; DecReady = 1'b0; Stall = 1'b0;
    BrTaken = 1'b0; BrTarget = 16'h0000;

    // Zero-wait memory from reset.
    do_reset();
    IAck = 1'b1; DecReady = 1'b1;
    @(negedge Clock_TB);
    check("c1_ireq",  {15'b0, IReq},       16'h1);
    check("c1_addr",  IAddr,               RV);
    check("c1_valid", {15'b0, InstrValid}, 16'h0);
    @(negedge Clock_TB);
    check("c2_valid", {15'b0, InstrValid}, 16'h1);
    check("c2_instr", Instr,               mem_word(RV));
    @(negedge Clock_TB);
    check("c3_addr",  IAddr,               16'h00A1);
    @(negedge Clock_TB);
    check("c4_instr", Instr,               mem_word(16'h00A1));
    @(negedge Clock_TB);
    check("c5_addr",  IAddr,               16'h00A2);
    @(negedge Clock_TB);
    check("c6_instr", Instr,               mem_word(16'h00A2));

    // Stall holds the instruction and the PC.
    Stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock_TB);
      check("stall_valid", {15'b0, InstrValid}, 16'h1);
      check("stall_instr", Instr,               mem_word(16'h00A2));
      check("stall_pc",    IAddr,               16'h00A2);
    end
    Stall = 1'b0;
    @(negedge Clock_TB);
    check("unstall_pc",    IAddr,               16'h00A3);
    check("unstall_valid", {15'b0, InstrValid}, 16'h0);
    DecReady = 1'b0;
    wait_valid("unstall_wait");

    // Branch in HOLD beats accept and drops the held instruction.
    BrTaken = 1'b1; BrTarget = 16'h0100; DecReady = 1'b1;
    @(negedge Clock_TB);
    BrTaken = 1'b0; DecReady = 1'b0;
    check("brh_valid", {15'b0, InstrValid}, 16'h0);
    check("brh_addr",  IAddr,               16'h0100);
    wait_valid("brh_wait");
    check("brh_instr", Instr,               mem_word(16'h0100));

    // PC wrap from 0xFFFF.
    BrTaken = 1'b1; BrTarget = 16'hFFFF;
    @(negedge Clock_TB);
    BrTaken = 1'b0;
    wait_valid("wrap_wait");
    check("wrap_held", IAddr, 16'hFFFF);
    DecReady = 1'b1;
    @(negedge Clock_TB);
    DecReady = 1'b0;
    check("wrap_addr", IAddr, 16'h0000);

    // Branch in FETCH while the ack is 3 cycles late.
    do_reset();
    IAck = 1'b0;
    @(negedge Clock_TB);
    BrTaken = 1'b1; BrTarget = 16'h0200;
    check("brf_addr0", IAddr, RV);
    @(negedge Clock_TB);
    BrTaken = 1'b0;
    check("brf_addr1", IAddr, RV);
    @(negedge Clock_TB);
    check("brf_addr2", IAddr, RV);
    @(negedge Clock_TB);
    IAck = 1'b1;
    check("brf_addr3", IAddr, RV);
    @(negedge Clock_TB);
    IAck = 1'b0;
    check("brf_novalid", {15'b0, InstrValid}, 16'h0);
    check("brf_target",  IAddr,               16'h0200);
    check("brf_ireq",    {15'b0, IReq},       16'h1);
    IAck = 1'b1;
    wait_valid("brf_wait");
    check("brf_instr", Instr, mem_word(16'h0200));

`ifdef PC_FETCH_TIMEOUT_EN
    // Watchdog: four FETCH cycles without ack.
    do_reset();
    IAck = 1'b0;
    repeat (4) @(negedge Clock_TB);
    check("to_err_early", {15'b0, FetchErr}, 16'h0);
    @(negedge Clock_TB);
    check("to_err",  {15'b0, FetchErr}, 16'h1);
    check("to_ireq", {15'b0, IReq},     16'h0);
    BrTaken = 1'b1; BrTarget = 16'h0300; IAck = 1'b1;
    @(negedge Clock_TB);
    BrTaken = 1'b0;
    @(negedge Clock_TB);
    check("halt_addr",  IAddr,               RV);
    check("halt_ireq",  {15'b0, IReq},       16'h0);
    check("halt_valid", {15'b0, InstrValid}, 16'h0);
    check("halt_err",   {15'b0, FetchErr},   16'h1);
    do_reset();
    @(negedge Clock_TB);
    check("rec_ireq", {15'b0, IReq},     16'h1);
    check("rec_addr", IAddr,             RV);
    check("rec_err",  {15'b0, FetchErr}, 16'h0);
`else
    // Without the watchdog FETCH waits indefinitely.
    do_reset();
    IAck = 1'b0;
    repeat (10) @(negedge Clock_TB);
    check("wait_err",  {15'b0, FetchErr}, 16'h0);
    check("wait_ireq", {15'b0, IReq},     16'h1);
    check("wait_addr", IAddr,             RV);
`endif

    // Randomized run against the program-order reference model.
    do_reset();
    exp_q.delete();
    exp_q.push_back(RV);
    noack  = 0;
    mon_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clock_TB);
      IAck = ($urandom_range(0, 2) != 0);
      if (noack >= 2) IAck = 1'b1;
      if (IReq && !IAck) noack++;
      else noack = 0;
      DecReady = ($urandom_range(0, 1) == 1);
      Stall    = ($urandom_range(0, 3) == 0);
      BrTaken  = ($urandom_range(0, 11) == 0);
      BrTarget = ($urandom_range(0, 3) == 0) ? (16'hFFFF - 16'($urandom_range(0, 2)))
                                             : 16'($urandom);
      if (BrTaken) begin
        exp_q.delete();
        exp_q.push_back(BrTarget);
      end else if (InstrValid && DecReady && !Stall) begin
        exp_q.push_back(held_addr + 16'd1);
      end
    end
    @(negedge Clock_TB);
    BrTaken = 1'b0; DecReady = 1'b0;
    mon_en = 1'b0;
    checks++;
    if (deliveries < 200) begin
      fails++;
      $display("FAIL rand_deliveries: got %0d expected at least 200", deliveries);
    end
    checks++;
    if (exp_q.size() > 1) begin
      fails++;
      $display("FAIL rand_backlog: got %0d pending expected at most 1", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
# pc_fetch_sequencer

Fetch-stage controller for the softcore program counter. It owns one `Register` instance used as the PC and drives that instance's active-low `Reset`/`LD` strobes and `DIn`. It runs the instruction-memory request/acknowledge handshake and presents fetched words to decode with a valid/ready handshake. It also applies sequential increment, branch redirect, stall and (optionally) fetch-timeout policy.

## Interface
- `DataWidth`, 16: PC, address and instruction width.
- `ResetVector`, 16'h0000: first fetch address after reset.
- `StepSize`, 1: PC increment per accepted instruction.
- `TimeoutCycles`, 255: FETCH cycles without `IAck` before error; used only with the macro.
- `Clk` in 1: single clock; all state updates on rising edge.
- `Reset` in 1: synchronous, active-high.
- `IReq` out 1: instruction-memory request.
- `IAddr` out DataWidth: fetch address; always equals the PC.
- `IAck` in 1: memory acknowledge; `IData` is valid in the same cycle.
- `IData` in DataWidth: fetched word.
- `InstrValid` out 1: `Instr` is valid for decode.
- `Instr` out DataWidth: held instruction.
- `DecReady` in 1: decode accepts `Instr`.
- `Stall` in 1: pipeline stall; blocks acceptance.
- `BrTaken` in 1: redirect request, single-cycle pulse.
- `BrTarget` in DataWidth: redirect address.
- `FetchErr` out 1: sticky fetch timeout flag.

## Operation
- FSM states: `RESET`, `FETCH`, `HOLD`, `HALT`.
- `Reset` high:
  - state goes to `RESET` and the PC register's active-low reset is asserted, so PC = 0.
  - `IReq`, `InstrValid` and `FetchErr` = 0; `Instr` = 0; `RedirPend` = 0.
- `RESET`:
  - lasts one cycle after `Reset` falls.
  - drives `LD` low with `DIn` = `ResetVector`, then goes to `FETCH`.
- `FETCH`:
  - `IReq` = 1 and `IAddr` is held stable until `IAck`.
  - On `IAck` with no redirect pending: `Instr` <= `IData`, go to `HOLD`.
- `HOLD`:
  - `InstrValid` = 1 and `Instr` is stable.
  - Accept = `DecReady` & ~`Stall`.
  - On accept: PC <= PC + `StepSize` modulo 2^DataWidth (0xFFFF wraps to 0x0000), go to `FETCH`.
- Branch in `HOLD`: PC <= `BrTarget` and the state goes to `FETCH`. This takes priority over accept; the held instruction is dropped, not consumed.
- Branch in `FETCH` without `IAck`: the request is never aborted.
  - `RedirTarget` <= `BrTarget` and `RedirPend` <= 1; a later branch overwrites the target (latest wins).
  - On `IAck` with `RedirPend` set: `IData` is discarded, PC <= `RedirTarget`, `RedirPend` <= 0, state stays `FETCH`.
- Branch in the same cycle as `IAck`: the data is discarded, PC <= `BrTarget`, state stays `FETCH`.
- `BrTaken` is ignored in `RESET` and `HALT`.
- Priority order: `Reset` > timeout > branch > `IAck`/accept.

## Timing
- Every output is registered except `IAddr`, which is the PC register output.
- Zero-wait memory (`IAck` tied high):
  - cycle 0 after `Reset` falls: `RESET`.
  - cycle 1: `IReq` with `IAddr` = `ResetVector`.
  - cycle 2: `InstrValid`.
- Peak throughput is 1 instruction per 2 cycles.
- Branch in `HOLD` at cycle n: `InstrValid` = 0 and `IAddr` = target at n+1.
- A PC update is visible on `IAddr` one cycle after the decision.
- Reset asserted mid-`FETCH` or mid-`HOLD` takes effect at the next edge; the outstanding request is abandoned and memory must tolerate this.

## Configuration
- Macro: `PC_FETCH_TIMEOUT_EN`.
- Defined:
  - A counter (width clog2(TimeoutCycles+1)) clears on entering `FETCH` and counts each `FETCH` cycle without `IAck`.
  - When it reaches `TimeoutCycles`: `FetchErr` <= 1 (sticky), `IReq` <= 0, state goes to `HALT`.
  - Only `Reset` exits `HALT`.
- Undefined: no counter, `FETCH` waits indefinitely, `FetchErr` is tied 0 and `HALT` is unreachable.

## Structure
- Shared package `softcore_pkg`: FSM state encoding, the `ResetVector` default and the `DataWidth` default.
- Sub-module: the existing `Register` as the PC, instance `pc_reg`.
  - The sequencer drives its active-low `Reset` and `LD`.
  - Its `DIn` is selected from `ResetVector`, PC+`StepSize`, `BrTarget` or `RedirTarget`.
- Timeout counter is inline, guarded by the macro.

## Test plan
- Reset release, `ResetVector` = 16'h00A0, `IAck` = 1, `DecReady` = 1: `IAddr` steps 00A0, 00A1, 00A2 on alternate cycles; `Instr` mirrors `IData`.
- In `HOLD` with `Stall` = 1 and `DecReady` = 1 for 5 cycles: `InstrValid` stays 1, `Instr` and PC are unchanged; the PC increments once after `Stall` falls.
- `BrTaken` in `HOLD`, target 16'h0100: the next cycle has `InstrValid` = 0 and `IAddr` = 0100; the old instruction is never accepted.
- `BrTaken` in `FETCH` at PC 00A0 with `IAck` delayed 3 cycles, target 0200:
  - `IAddr` holds 00A0 until ack.
  - No `InstrValid` follows the ack.
  - Next `IAddr` = 0200.
- PC = 16'hFFFF accepted: next `IAddr` = 16'h0000.
- Macro on, `TimeoutCycles` = 4, `IAck` = 0:
  - `FetchErr` = 1 and `IReq` = 0 after 4 `FETCH` cycles.
  - Branches are ignored.
  - `Reset` restores a fetch at `ResetVector` with `FetchErr` = 0.
